multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle FSM that drives the 16-bit datapath through IF/ID/EX/MEM/WB (plus HALT).
//  Per state and opcode it issues PC write, IR write, memory, register-write and ALU control
//  (ALUSrcA/B, ALUOp, carry). It sits between the memory handshake and the ALU/regfile.
// PARAMETERS
//  WORD_SIZE  16  instruction/data width
//  OP_SIZE     4  opcode field inst[15:12]
//  FUNC_SIZE   6  R-type func field inst[5:0]
// PORTS
//  clk         in   1   clock, all state changes on rising edge
//  reset_n     in   1   synchronous active-low reset
//  inst        in   16  instruction register contents
//  mem_ready   in   1   memory completed current request this cycle
//  bcond       in   1   branch condition from datapath comparator (valid in EX)
//  mem_read    out  1   memory read request (IF, or MEM for LWD)
//  mem_write   out  1   memory write request (MEM for SWD)
//  IorD        out  1   0=address from PC, 1=from ALUOut
//  IRWrite     out  1   latch fetched word into IR
//  PVSWriteEn  out  1   PC write enable
//  PCSource    out  2   0=ALU result, 1=ALUOut (branch target), 2=jump target, 3=register
//  RegWrite    out  1   register file write enable
//  RegDst      out  2   0=rt, 1=rd, 2=$2 (link)
//  MemtoReg    out  1   1=write-back from MDR
//  ALUSrcA     out  2   0=PC, 1=RegA
//  ALUSrcB     out  2   0=RegB, 1=const 1, 2=sign-ext imm, 3=zero-ext imm
//  ALUOp       out  4   ALU function (encodings below)
//  carry       out  1   ALU carry-in (1 only for TCP)
//  out_en      out  1   WWD output-port strobe
//  is_halted   out  1   HLT executed
// BEHAVIOUR
//  - reset_n low at a rising edge: state<=IF, outstanding memory request dropped. Every output
//    is 0 while reset_n is low. After release, first cycle is IF.
//  - Outputs are combinational from state+inst. Only `state` is registered.
//  - IF: mem_read=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD. Hold IF until mem_ready.
//    On mem_ready: IRWrite=1, PVSWriteEn=1, PCSource=0 -> ID. Minimum 1 cycle per state.
//  - ID: ALUSrcA=0, ALUSrcB=2, ALUOp=ADD (branch target -> ALUOut).
//    HLT -> HALT. JMP/JPR: PVSWriteEn=1, PCSource=2/3 -> IF.
//    JAL/JRL: PVSWriteEn=1 -> WB, which writes the link to $2 (RegDst=2). All others -> EX.
//  - EX: R-type ALUSrcA=1, ALUSrcB=0. ADI/LWD/SWD use ALUSrcB=2. ORI uses ALUSrcB=3.
//    ALUOp: ADD 0000, SUB 0001, AND 1101, OR 1110, NOT 1100, TCP 1100 with carry=1,
//    ALS 0101, ARS 0100, LHI 1010.
//    Branches (op 0-3): ALUOp=SUB, PVSWriteEn=bcond, PCSource=1 -> IF.
//    WWD: out_en=1 -> IF. LWD/SWD -> MEM. ALU/imm -> WB.
//  - MEM: IorD=1, mem_read (LWD) or mem_write (SWD) held until mem_ready.
//    On mem_ready: LWD -> WB, SWD -> IF.
//  - WB: RegWrite=1 for exactly one cycle. RegDst=1 for R-type, 0 for imm/LWD.
//    MemtoReg=1 for LWD only. -> IF.
//  - HALT: all outputs 0 except is_halted=1. Exit only via reset.
//  - Unknown opcode or func: treated as NOP, ID -> IF with no writes.
//  - mem_ready outside IF/MEM is ignored. mem_ready asserted in the same cycle as request
//    entry is legal (1-cycle IF/MEM).
// CONFIGURATION
//  INST_COUNT_EN defined: adds output num_inst[WORD_SIZE-1:0]. It is zeroed by reset and
//  increments once per retired instruction, i.e. on every transition into IF from
//  ID/EX/MEM/WB, plus 1 when entering HALT. Wraps 16'hFFFF->0.
//  INST_COUNT_EN not defined: port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared header: WORD_SIZE, OP_SIZE, FUNC_SIZE, opcode/func codes, state codes
//    (IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5), ALUOp encodings.
//  - One sub-module inst_class_decoder: combinational inst -> {is_rtype, is_branch,
//    is_jump, is_link, is_load, is_store, is_imm, is_wwd, is_hlt}.
// TESTING
//  1. reset_n=0 for 2 clk, mem_ready=1 -> all outputs 0. After release: IF, mem_read=1,
//     then ID next cycle.
//  2. ADD (op 15, func 0), mem_ready always 1 -> IF,ID,EX(ALUOp 0000),WB(RegWrite=1),IF.
//     Exactly 4 cycles.
//  3. LWD with mem_ready low 3 cycles in MEM -> MEM held 4 cycles with IorD=1, mem_read=1,
//     then WB with MemtoReg=1.
//  4. BEQ with bcond=1 -> EX PVSWriteEn=1, PCSource=1.
//     Same with bcond=0 -> PVSWriteEn=0. Both return to IF.
//  5. TCP (func 5) -> EX ALUOp=1100, carry=1. NOT (func 4) -> carry=0.
//  6. HLT -> is_halted=1 held 10 cycles. reset_n pulse mid-LWD MEM -> IF, mem_read
//     re-fetches. With INST_COUNT_EN, num_inst counts 3 after ADD, LWD, HLT.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared ISA, state and ALU-control definitions for the multi-cycle sequencer.
package multicycle_sequencer_pkg;

    localparam int WORD_SIZE = 16;
    localparam int OP_SIZE   = 4;
    localparam int FUNC_SIZE = 6;

    localparam logic [OP_SIZE-1:0] OP_BNE   = 4'd0;
    localparam logic [OP_SIZE-1:0] OP_BEQ   = 4'd1;
    localparam logic [OP_SIZE-1:0] OP_BGZ   = 4'd2;
    localparam logic [OP_SIZE-1:0] OP_BLZ   = 4'd3;
    localparam logic [OP_SIZE-1:0] OP_ADI   = 4'd4;
    localparam logic [OP_SIZE-1:0] OP_ORI   = 4'd5;
    localparam logic [OP_SIZE-1:0] OP_LHI   = 4'd6;
    localparam logic [OP_SIZE-1:0] OP_LWD   = 4'd7;
    localparam logic [OP_SIZE-1:0] OP_SWD   = 4'd8;
    localparam logic [OP_SIZE-1:0] OP_JMP   = 4'd9;
    localparam logic [OP_SIZE-1:0] OP_JAL   = 4'd10;
    localparam logic [OP_SIZE-1:0] OP_RTYPE = 4'd15;

    localparam logic [FUNC_SIZE-1:0] FN_ADD = 6'd0;
    localparam logic [FUNC_SIZE-1:0] FN_SUB = 6'd1;
    localparam logic [FUNC_SIZE-1:0] FN_AND = 6'd2;
    localparam logic [FUNC_SIZE-1:0] FN_ORR = 6'd3;
    localparam logic [FUNC_SIZE-1:0] FN_NOT = 6'd4;
    localparam logic [FUNC_SIZE-1:0] FN_TCP = 6'd5;
    localparam logic [FUNC_SIZE-1:0] FN_ALS = 6'd6;
    localparam logic [FUNC_SIZE-1:0] FN_ARS = 6'd7;
    localparam logic [FUNC_SIZE-1:0] FN_JPR = 6'd25;
    localparam logic [FUNC_SIZE-1:0] FN_JRL = 6'd26;
    localparam logic [FUNC_SIZE-1:0] FN_WWD = 6'd28;
    localparam logic [FUNC_SIZE-1:0] FN_HLT = 6'd29;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1101;
    localparam logic [3:0] ALU_OR  = 4'b1110;
    localparam logic [3:0] ALU_NOT = 4'b1100;
    localparam logic [3:0] ALU_ALS = 4'b0101;
    localparam logic [3:0] ALU_ARS = 4'b0100;
    localparam logic [3:0] ALU_LHI = 4'b1010;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef struct packed {
        logic is_rtype;
        logic is_branch;
        logic is_jump;
        logic is_link;
        logic is_load;
        logic is_store;
        logic is_imm;
        logic is_wwd;
        logic is_hlt;
    } inst_class_t;

    // TCP shares the NOT encoding; the carry-in distinguishes it.
    function automatic logic [3:0] rtype_alu_op(input logic [FUNC_SIZE-1:0] fn);
        logic [3:0] op;
        case (fn)
            FN_ADD:         op = ALU_ADD;
            FN_SUB:         op = ALU_SUB;
            FN_AND:         op = ALU_AND;
            FN_ORR:         op = ALU_OR;
            FN_NOT, FN_TCP: op = ALU_NOT;
            FN_ALS:         op = ALU_ALS;
            FN_ARS:         op = ALU_ARS;
            default:        op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction, memory handshake and datapath control bundle of the sequencer.
interface multicycle_sequencer_if;
    import multicycle_sequencer_pkg::*;

    logic [WORD_SIZE-1:0] inst;
    logic                 mem_ready;
    logic                 bcond;
    logic                 mem_read;
    logic                 mem_write;
    logic                 IorD;
    logic                 IRWrite;
    logic                 PVSWriteEn;
    logic [1:0]           PCSource;
    logic                 RegWrite;
    logic [1:0]           RegDst;
    logic                 MemtoReg;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [3:0]           ALUOp;
    logic                 carry;
    logic                 out_en;
    logic                 is_halted;

    modport master (
        input  inst, mem_ready, bcond,
        output mem_read, mem_write, IorD, IRWrite, PVSWriteEn, PCSource,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
               carry, out_en, is_halted
    );

    modport slave (
        output inst, mem_ready, bcond,
        input  mem_read, mem_write, IorD, IRWrite, PVSWriteEn, PCSource,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
               carry, out_en, is_halted
    );

endinterface

// File: rtl/multicycle_sequencer_inst_class_decoder.sv
// Combinational instruction classifier; unknown opcodes/funcs yield an all-zero class (NOP).
module inst_class_decoder
    import multicycle_sequencer_pkg::*;
(
    input  logic [WORD_SIZE-1:0] inst,
    output inst_class_t          cls
);

    logic [OP_SIZE-1:0]   op_s;
    logic [FUNC_SIZE-1:0] fn_s;
    logic                 unused_inst_bits_s;

    assign op_s               = inst[15:12];
    assign fn_s               = inst[5:0];
    assign unused_inst_bits_s = ^inst[11:6];

    // Classify by opcode, then by func for the R-type group
    always_comb begin
        cls = '0;
        case (op_s)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls.is_branch = 1'b1;
            OP_ADI, OP_ORI, OP_LHI:         cls.is_imm    = 1'b1;
            OP_LWD:                         cls.is_load   = 1'b1;
            OP_SWD:                         cls.is_store  = 1'b1;
            OP_JMP:                         cls.is_jump   = 1'b1;
            OP_JAL:                         cls.is_link   = 1'b1;
            OP_RTYPE: begin
                case (fn_s)
                    FN_ADD, FN_SUB, FN_AND, FN_ORR,
                    FN_NOT, FN_TCP, FN_ALS, FN_ARS: cls.is_rtype = 1'b1;
                    FN_JPR:  cls.is_jump = 1'b1;
                    FN_JRL:  cls.is_link = 1'b1;
                    FN_WWD:  cls.is_wwd  = 1'b1;
                    FN_HLT:  cls.is_hlt  = 1'b1;
                    default: cls = '0;
                endcase
            end
            default: cls = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// IF/ID/EX/MEM/WB/HALT control FSM for a 16-bit multi-cycle datapath.
// Optional INST_COUNT_EN adds a retired-instruction counter output num_inst.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    multicycle_sequencer_if.master bus
`ifdef INST_COUNT_EN
    ,
    output logic [WORD_SIZE-1:0]  num_inst
`endif
);

    state_t               state_q;
    state_t               state_d;
    inst_class_t          cls_s;
    logic [OP_SIZE-1:0]   op_s;
    logic [FUNC_SIZE-1:0] fn_s;
    logic                 reg_target_s;

    assign op_s         = bus.inst[15:12];
    assign fn_s         = bus.inst[5:0];
    assign reg_target_s = (op_s == OP_RTYPE);

    inst_class_decoder u_decoder (
        .inst (bus.inst),
        .cls  (cls_s)
    );

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (bus.mem_ready) state_d = S_ID;
                else               state_d = S_IF;
            end
            S_ID: begin
                if (cls_s.is_hlt)       state_d = S_HALT;
                else if (cls_s.is_jump) state_d = S_IF;
                else if (cls_s.is_link) state_d = S_WB;
                else if (cls_s.is_rtype || cls_s.is_branch || cls_s.is_imm ||
                         cls_s.is_load  || cls_s.is_store  || cls_s.is_wwd)
                                        state_d = S_EX;
                else                    state_d = S_IF;
            end
            S_EX: begin
                if (cls_s.is_load || cls_s.is_store)     state_d = S_MEM;
                else if (cls_s.is_rtype || cls_s.is_imm) state_d = S_WB;
                else                                     state_d = S_IF;
            end
            S_MEM: begin
                if (!bus.mem_ready)     state_d = S_MEM;
                else if (cls_s.is_load) state_d = S_WB;
                else                    state_d = S_IF;
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IF;
        else          state_q <= state_d;
    end

    // Control outputs decoded from state and instruction; forced low during reset
    always_comb begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.IorD       = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PVSWriteEn = 1'b0;
        bus.PCSource   = 2'd0;
        bus.RegWrite   = 1'b0;
        bus.RegDst     = 2'd0;
        bus.MemtoReg   = 1'b0;
        bus.ALUSrcA    = 2'd0;
        bus.ALUSrcB    = 2'd0;
        bus.ALUOp      = ALU_ADD;
        bus.carry      = 1'b0;
        bus.out_en     = 1'b0;
        bus.is_halted  = 1'b0;
        if (!reset_n) begin
            bus.is_halted = 1'b0;
        end else begin
            case (state_q)
                S_IF: begin
                    bus.mem_read   = 1'b1;
                    bus.ALUSrcB    = 2'd1;
                    bus.IRWrite    = bus.mem_ready;
                    bus.PVSWriteEn = bus.mem_ready;
                end
                S_ID: begin
                    bus.ALUSrcB = 2'd2;
                    if (cls_s.is_jump || cls_s.is_link) begin
                        bus.PVSWriteEn = 1'b1;
                        bus.PCSource   = reg_target_s ? 2'd3 : 2'd2;
                    end else begin
                        bus.PVSWriteEn = 1'b0;
                    end
                end
                S_EX: begin
                    if (cls_s.is_rtype) begin
                        bus.ALUSrcA = 2'd1;
                        bus.ALUOp   = rtype_alu_op(fn_s);
                        bus.carry   = (fn_s == FN_TCP);
                    end else if (cls_s.is_imm) begin
                        bus.ALUSrcA = 2'd1;
                        case (op_s)
                            OP_ORI: begin
                                bus.ALUSrcB = 2'd3;
                                bus.ALUOp   = ALU_OR;
                            end
                            OP_LHI: begin
                                bus.ALUSrcB = 2'd3;
                                bus.ALUOp   = ALU_LHI;
                            end
                            default: bus.ALUSrcB = 2'd2;
                        endcase
                    end else if (cls_s.is_load || cls_s.is_store) begin
                        bus.ALUSrcA = 2'd1;
                        bus.ALUSrcB = 2'd2;
                    end else if (cls_s.is_branch) begin
                        bus.ALUSrcA    = 2'd1;
                        bus.ALUOp      = ALU_SUB;
                        bus.PVSWriteEn = bus.bcond;
                        bus.PCSource   = 2'd1;
                    end else if (cls_s.is_wwd) begin
                        bus.ALUSrcA = 2'd1;
                        bus.out_en  = 1'b1;
                    end else begin
                        bus.out_en = 1'b0;
                    end
                end
                S_MEM: begin
                    bus.IorD      = 1'b1;
                    bus.mem_read  = cls_s.is_load;
                    bus.mem_write = cls_s.is_store;
                end
                S_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = cls_s.is_load;
                    if (cls_s.is_link)       bus.RegDst = 2'd2;
                    else if (cls_s.is_rtype) bus.RegDst = 2'd1;
                    else                     bus.RegDst = 2'd0;
                end
                S_HALT:  bus.is_halted = 1'b1;
                default: bus.is_halted = 1'b0;
            endcase
        end
    end

`ifdef INST_COUNT_EN
    logic [WORD_SIZE-1:0] num_inst_q;
    logic [WORD_SIZE-1:0] num_inst_d;
    logic                 retire_s;

    // An instruction retires on returning to IF from an execution state, or on entering HALT
    always_comb begin
        retire_s = ((state_d == S_IF) && (state_q != S_IF) && (state_q != S_HALT)) ||
                   ((state_d == S_HALT) && (state_q != S_HALT));
        if (retire_s) num_inst_d = num_inst_q + 16'd1;
        else          num_inst_d = num_inst_q;
    end

    // Retired-instruction counter register
    always_ff @(posedge clk) begin
        if (!reset_n) num_inst_q <= '0;
        else          num_inst_q <= num_inst_d;
    end

    assign num_inst = reset_n ? num_inst_q : '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomised scoreboard bench for multicycle_sequencer: per-instruction cycle scripts feed an expected queue.
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] alu_op;
        logic       carry;
        logic       out_en;
        logic       halted;
    } ctrl_t;

    typedef enum int {
        K_NOP, K_RALU, K_ADI, K_ORI, K_LHI, K_LWD, K_SWD, K_BR,
        K_JMP, K_JPR, K_JAL, K_JRL, K_WWD, K_HLT
    } kind_e;

    logic clk;
    logic reset_n;
    multicycle_sequencer_if bus();
`ifdef INST_COUNT_EN
    logic [15:0] num_inst;
`endif

    multicycle_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef INST_COUNT_EN
        ,
        .num_inst (num_inst)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctrl_t       act_s;
    ctrl_t       exp_q[$];
    logic [15:0] cnt_q[$];
    string       name_q[$];
    int          errors = 0;
    int          checks = 0;
    int          model_count = 0;

    assign act_s = {bus.mem_read, bus.mem_write, bus.IorD, bus.IRWrite, bus.PVSWriteEn,
                    bus.PCSource, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA,
                    bus.ALUSrcB, bus.ALUOp, bus.carry, bus.out_en, bus.is_halted};

    ctrl_t       mon_e;
    logic [15:0] mon_c;
    string       mon_n;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_c = cnt_q.pop_front();
            mon_n = name_q.pop_front();
            checks++;
            if (act_s !== mon_e) begin
                errors++;
                $display("FAIL %s: controls got %b want %b", mon_n, act_s, mon_e);
            end
`ifdef INST_COUNT_EN
            checks++;
            if (num_inst !== mon_c) begin
                errors++;
                $display("FAIL %s num_inst: got %0d want %0d", mon_n, num_inst, mon_c);
            end
`endif
        end
    end

    function automatic kind_e classify(input logic [15:0] w);
        kind_e k;
        case (w[15:12])
            4'd0, 4'd1, 4'd2, 4'd3: k = K_BR;
            4'd4:  k = K_ADI;
            4'd5:  k = K_ORI;
            4'd6:  k = K_LHI;
            4'd7:  k = K_LWD;
            4'd8:  k = K_SWD;
            4'd9:  k = K_JMP;
            4'd10: k = K_JAL;
            4'd15: begin
                case (w[5:0])
                    6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7: k = K_RALU;
                    6'd25:   k = K_JPR;
                    6'd26:   k = K_JRL;
                    6'd28:   k = K_WWD;
                    6'd29:   k = K_HLT;
                    default: k = K_NOP;
                endcase
            end
            default: k = K_NOP;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] ralu_op(input logic [5:0] fn);
        logic [3:0] r;
        case (fn)
            6'd0:       r = 4'b0000;
            6'd1:       r = 4'b0001;
            6'd2:       r = 4'b1101;
            6'd3:       r = 4'b1110;
            6'd4, 6'd5: r = 4'b1100;
            6'd6:       r = 4'b0101;
            6'd7:       r = 4'b0100;
            default:    r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [5:0] fn);
        logic [5:0] mid;
        mid = 6'($urandom);
        return {op, mid, fn};
    endfunction

    task automatic step(input ctrl_t c, input logic [15:0] w, input logic rdy,
                        input logic bc, input string nm);
        bus.inst      = w;
        bus.mem_ready = rdy;
        bus.bcond     = bc;
        exp_q.push_back(c);
        cnt_q.push_back(16'(model_count));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        model_count = 0;
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) step('0, 16'($urandom), 1'b1, 1'($urandom), "reset");
        reset_n = 1'b1;
    endtask

    task automatic halt_cycles(input int n);
        ctrl_t c;
        c = '0;
        c.halted = 1'b1;
        for (int i = 0; i < n; i++) step(c, 16'($urandom), 1'($urandom), 1'($urandom), "halt");
    endtask

    // One instruction from fetch to retirement; cut stops it inside a stalled MEM phase
    task automatic run_instr(input logic [15:0] w, input logic bc, input int if_wait,
                             input int mem_wait, input bit cut, input string tag);
        ctrl_t c;
        kind_e k;
        logic  rdy;
        k = classify(w);
        for (int i = 0; i <= if_wait; i++) begin
            rdy = (i == if_wait);
            c = '0;
            c.mem_read = 1'b1;
            c.src_b    = 2'd1;
            c.ir_write = rdy;
            c.pc_write = rdy;
            step(c, 16'($urandom), rdy, 1'($urandom), {tag, "/fetch"});
        end

        c = '0;
        c.src_b = 2'd2;
        if (k == K_JMP || k == K_JAL) begin c.pc_write = 1'b1; c.pc_source = 2'd2; end
        if (k == K_JPR || k == K_JRL) begin c.pc_write = 1'b1; c.pc_source = 2'd3; end
        step(c, w, 1'($urandom), 1'($urandom), {tag, "/decode"});
        if (k == K_NOP || k == K_JMP || k == K_JPR || k == K_HLT) begin
            model_count++;
            return;
        end
        if (k == K_JAL || k == K_JRL) begin
            c = '0;
            c.reg_write = 1'b1;
            c.reg_dst   = 2'd2;
            step(c, w, 1'($urandom), 1'($urandom), {tag, "/link"});
            model_count++;
            return;
        end

        c = '0;
        c.src_a = 2'd1;
        case (k)
            K_RALU: begin c.alu_op = ralu_op(w[5:0]); c.carry = (w[5:0] == 6'd5); end
            K_ADI, K_LWD, K_SWD: c.src_b = 2'd2;
            K_ORI:  begin c.src_b = 2'd3; c.alu_op = 4'b1110; end
            K_LHI:  begin c.src_b = 2'd3; c.alu_op = 4'b1010; end
            K_BR:   begin c.alu_op = 4'b0001; c.pc_write = bc; c.pc_source = 2'd1; end
            K_WWD:  c.out_en = 1'b1;
            default: c.src_a = 2'd1;
        endcase
        step(c, w, 1'($urandom), (k == K_BR) ? bc : 1'($urandom), {tag, "/execute"});
        if (k == K_BR || k == K_WWD) begin
            model_count++;
            return;
        end

        if (k == K_LWD || k == K_SWD) begin
            for (int i = 0; i <= mem_wait; i++) begin
                rdy = (i == mem_wait);
                if (cut && rdy) return;
                c = '0;
                c.iord      = 1'b1;
                c.mem_read  = (k == K_LWD);
                c.mem_write = (k == K_SWD);
                step(c, w, rdy, 1'($urandom), {tag, "/memory"});
            end
            if (k == K_SWD) begin
                model_count++;
                return;
            end
        end

        c = '0;
        c.reg_write  = 1'b1;
        c.reg_dst    = (k == K_RALU) ? 2'd1 : 2'd0;
        c.mem_to_reg = (k == K_LWD);
        step(c, w, 1'($urandom), 1'($urandom), {tag, "/writeback"});
        model_count++;
    endtask

    initial begin
        logic [15:0] w;
        logic [3:0]  op;
        logic [5:0]  fn;
        int          pick;
        reset_n       = 1'b0;
        bus.inst      = 16'd0;
        bus.mem_ready = 1'b1;
        bus.bcond     = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        run_instr(mk(OP_RTYPE, FN_ADD), 1'b0, 0, 0, 1'b0, "add");
        run_instr(mk(OP_LWD, 6'($urandom)), 1'b0, 0, 3, 1'b0, "lwd_stall");
        run_instr(mk(OP_BEQ, 6'($urandom)), 1'b1, 0, 0, 1'b0, "beq_taken");
        run_instr(mk(OP_BEQ, 6'($urandom)), 1'b0, 1, 0, 1'b0, "beq_not_taken");
        run_instr(mk(OP_RTYPE, FN_TCP), 1'b0, 0, 0, 1'b0, "tcp");
        run_instr(mk(OP_RTYPE, FN_NOT), 1'b0, 0, 0, 1'b0, "not");
        run_instr(mk(OP_LWD, 6'($urandom)), 1'b0, 0, 2, 1'b1, "lwd_cut");
        do_reset(1);
        run_instr(mk(OP_RTYPE, FN_ADD), 1'b0, 0, 0, 1'b0, "add_after_reset");
        run_instr(mk(OP_LWD, 6'($urandom)), 1'b0, 0, 1, 1'b0, "lwd_count");
        run_instr(mk(OP_RTYPE, FN_HLT), 1'b0, 0, 0, 1'b0, "hlt");
        halt_cycles(10);
        do_reset(2);

        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom);
            if (op == OP_RTYPE) begin
                pick = int'($urandom_range(0, 12));
                if (pick < 8)       fn = 6'(pick);
                else if (pick == 8) fn = FN_JPR;
                else if (pick == 9) fn = FN_JRL;
                else if (pick == 10) fn = FN_WWD;
                else if (pick == 11) fn = FN_HLT;
                else                fn = 6'd40;
            end else begin
                fn = 6'($urandom);
            end
            w = mk(op, fn);
            run_instr(w, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'b0, $sformatf("rand%0d", n));
            if (classify(w) == K_HLT) begin
                halt_cycles(3);
                do_reset(1);
            end
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
